// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner state encoding,
// default bus widths and the default debug starvation limit.
// No logic; imported by dmem_arbiter and arb_wait_counter.
package dmem_arb_pkg;

  localparam int AW_DEF           = 8;
  localparam int DW_DEF           = 8;
  localparam int DBG_MAX_WAIT_DEF = 4;
  localparam int WAIT_W           = 4;

  // Which requester owns the read data returning in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } own_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Purpose: saturating counter of consecutive denied debug cycles.
// Latency: count updates at the clock edge; hit is combinational from the count.
// Backpressure: none; inc is ignored once the count has reached limit.
// Ports: clk/reset (async active-high), inc, clr (clr dominates), limit, hit.
module arb_wait_counter
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  input  logic [WAIT_W-1:0] limit,
  output logic              hit
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != limit)) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: shares data_mem between the CPU MEM stage (priority) and a debug port.
// Latency: grant/stall same cycle; read data and rvalid one cycle after grant.
// Backpressure: cpu_stall holds the pipeline; debug waits at most DBG_MAX_WAIT cycles.
// Ports: cpu_* / dbg_* requester ports, mem_* to data_mem (mem_rdata combinational),
//        clk, reset (async active-high).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  logic    force_dbg;
  logic    cpu_gnt;
  own_e    state_q, state_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  // Counts debug cycles lost to the CPU; hit forces one debug grant.
  arb_wait_counter u_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (dbg_req & ~dbg_gnt),
    .clr   (~dbg_req | dbg_gnt),
    .limit (WAIT_W'(DBG_MAX_WAIT)),
    .hit   (force_dbg)
  );

  assign dbg_gnt   = dbg_req & (~cpu_req | force_dbg);
  assign cpu_gnt   = cpu_req & ~dbg_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory mux: ungranted cycles drive all-zero so no stray write can land.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end
  end

  // Owner FSM and read capture: the state names who gets rvalid next cycle.
  always_comb begin
    state_d     = OWN_NONE;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (cpu_gnt && !cpu_we) begin
      state_d     = OWN_CPU;
      cpu_rdata_d = mem_rdata;
    end else if (dbg_gnt && !dbg_we) begin
      state_d     = OWN_DBG;
      dbg_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OWN_NONE;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign cpu_rvalid = (state_q == OWN_CPU);
  assign dbg_rvalid = (state_q == OWN_DBG);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against a cycle-level reference model (priority rule, starvation streak,
// reference memory image, expected read returns).
module tb_dmem_arbiter;

  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we, mem_re;
  logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] tb_mem  [256];
  logic [7:0] ref_mem [256];

  int   n_checks = 0;
  int   n_errors = 0;
  int   streak;
  logic e_crv, e_drv;
  logic [7:0] e_crd, e_drd;
  logic last_cg, last_dg, obs_dg, obs_stall;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(8), .DBG_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Simple data_mem: combinational read, write at clock edge.
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    streak = 0;
    e_crv  = 1'b0;
    e_drv  = 1'b0;
    e_crd  = 8'h00;
    e_drd  = 8'h00;
  endtask

  // One cycle: drive after negedge, check combinational outputs, advance the
  // model across the posedge, then check registered outputs at the next negedge.
  task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                      input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd);
    logic dg, cg;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
    dg = dr && (!cr || streak == MAXW);
    cg = cr && !dg;
    obs_dg    = dbg_gnt;
    obs_stall = cpu_stall;
    chk("dbg_gnt",   dbg_gnt,   dg);
    chk("cpu_stall", cpu_stall, cr && !cg);
    chk("mem_we",    mem_we,    (cg && cw) || (dg && dw));
    chk("mem_re",    mem_re,    (cg && !cw) || (dg && !dw));
    chk("mem_addr",  mem_addr,  cg ? ca : (dg ? da : 8'h00));
    chk("mem_wdata", mem_wdata, cg ? cd : (dg ? dd : 8'h00));
    @(posedge clk);
    e_crv = cg && !cw;
    e_drv = dg && !dw;
    if (cg && !cw) e_crd = ref_mem[ca];
    if (dg && !dw) e_drd = ref_mem[da];
    if (cg && cw)  ref_mem[ca] = cd;
    if (dg && dw)  ref_mem[da] = dd;
    if (dr && !dg) streak = (streak < MAXW) ? streak + 1 : MAXW;
    else           streak = 0;
    last_cg = cg;
    last_dg = dg;
    @(negedge clk);
    chk("cpu_rvalid", cpu_rvalid, e_crv);
    chk("dbg_rvalid", dbg_rvalid, e_drv);
    chk("cpu_rdata",  cpu_rdata,  e_crd);
    chk("dbg_rdata",  dbg_rdata,  e_drd);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  logic       r_cr, r_cw, r_dr, r_dw;
  logic [7:0] r_ca, r_cd, r_da, r_dd;
  int         tries;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end
    model_reset();
    last_cg = 1'b0; last_dg = 1'b0; obs_dg = 1'b0; obs_stall = 1'b0;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    chk("rst_cpu_rdata",  cpu_rdata,  8'h00);
    chk("rst_dbg_rdata",  dbg_rdata,  8'h00);
    reset = 1'b0;

    // CPU only: write then read back.
    step(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("cpu_wr_mem", tb_mem[8'h10], 8'h5A);
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("cpu_rd_data", cpu_rdata, 8'h5A);

    // Debug only read.
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("dbg_rd_data", dbg_rdata, 8'h5A);
    chk("dbg_rd_cpu_quiet", cpu_rvalid, 1'b0);
    idle();

    // Continuous contention: debug wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      chk("contend_pattern", obs_dg, (i % 5) == 4);
    end
    idle();

    // Simultaneous writes to one address: CPU first, debug on its forced grant.
    step(1'b1, 1'b1, 8'h20, 8'h11, 1'b1, 1'b1, 8'h20, 8'h22);
    chk("simw_cpu_first", tb_mem[8'h20], 8'h11);
    tries = 0;
    do begin
      step(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'h20, 8'h22);
      tries++;
    end while (!last_dg && tries < 10);
    chk("simw_dbg_granted", last_dg, 1'b1);
    chk("simw_dbg_wait", tries, 4);
    chk("simw_dbg_late", tb_mem[8'h20], 8'h22);
    idle();

    // Stalled CPU read: denied by a forced grant, returned after its own grant.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 8'h50, 8'(i), 1'b1, 1'b0, 8'h40, 8'h00);
    step(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
    chk("stall_seen", obs_stall, 1'b1);
    chk("stall_no_rvalid", cpu_rvalid, 1'b0);
    step(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("stall_rvalid", cpu_rvalid, 1'b1);
    chk("stall_rdata", cpu_rdata, 8'h22);

    // Reset mid-operation with a read return in flight.
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    cpu_req = 0; dbg_req = 0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_rvalid", cpu_rvalid, 1'b0);
    chk("midrst_rdata",  cpu_rdata,  8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    idle();

    // Random traffic; requesters hold their request until granted.
    r_cr = 0; r_cw = 0; r_ca = 0; r_cd = 0;
    r_dr = 0; r_dw = 0; r_da = 0; r_dd = 0;
    last_cg = 0; last_dg = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(r_cr && !last_cg)) begin
        r_cr = ($urandom_range(0, 9) < 7);
        r_cw = $urandom_range(0, 1) == 1;
        r_ca = 8'($urandom_range(0, 15));
        r_cd = 8'($urandom);
      end
      if (!(r_dr && !last_dg)) begin
        r_dr = $urandom_range(0, 1) == 1;
        r_dw = $urandom_range(0, 1) == 1;
        r_da = 8'($urandom_range(0, 15));
        r_dd = 8'($urandom);
      end
      step(r_cr, r_cw, r_ca, r_cd, r_dr, r_dw, r_da, r_dd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
